// File: rtl/xor_multiport_ram_rw.sv
// xor_multiport_ram_rw: XOR-encoded multi-port RAM, WR_PORTS write / RD_PORTS read ports, zero-fill on reset.
// Latency: write commits 2 edges after sampling; read data/valid registered 2 edges after sampling.
// Backpressure: none per port; all requests are ignored while ready=0 (init); colliding writes drop and flag wr_conflict.
// Ports: clk/rst_n; ready; wr_en/wr_addr/wr_data -> wr_conflict; rd_en/rd_addr -> rd_valid/rd_data.
module xor_multiport_ram_rw #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 512,
  parameter int WR_PORTS      = 4,
  parameter int RD_PORTS      = 4,
  parameter int INIT_ON_RESET = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               ready,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]        wr_addr,
  input  logic [WR_PORTS-1:0][WIDTH-1:0]     wr_data,
  output logic [WR_PORTS-1:0]                wr_conflict,
  input  logic [RD_PORTS-1:0]                rd_en,
  input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr,
  output logic [RD_PORTS-1:0]                rd_valid,
  output logic [RD_PORTS-1:0][WIDTH-1:0]     rd_data
);

  // Each bank has one copy per reader: copies 0..WR_PORTS-2 serve the other
  // write ports, copies WR_PORTS-1.. serve the read ports.
  localparam int NCOPY = WR_PORTS - 1 + RD_PORTS;

  logic [WIDTH-1:0] mem [WR_PORTS][NCOPY][DEPTH];

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t        state;
  logic [AW-1:0] init_cnt;
  logic          init_we;

  logic [WR_PORTS-1:0]              s1_req;
  logic [WR_PORTS-1:0][AW-1:0]      s1_addr;
  logic [WR_PORTS-1:0][WIDTH-1:0]   s1_data;
  logic [WR_PORTS-1:0]              s1_win;
  logic [WR_PORTS-1:0][WIDTH-1:0]   s1_part;

  logic [WR_PORTS-1:0]              s2_vld;
  logic [WR_PORTS-1:0][AW-1:0]      s2_addr;
  logic [WR_PORTS-1:0][WIDTH-1:0]   s2_val;

  logic [RD_PORTS-1:0]              r1_vld;
  logic [RD_PORTS-1:0][AW-1:0]      r1_addr;
  logic [RD_PORTS-1:0][WIDTH-1:0]   r1_word;
  logic [RD_PORTS-1:0]              r2_vld;
  logic [RD_PORTS-1:0][WIDTH-1:0]   r2_word;

  // Init FSM: ready is registered and rises on the edge that zeroes DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if ((INIT_ON_RESET == 0) || (init_cnt == AW'(DEPTH - 1))) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign init_we = (state == ST_INIT) && (INIT_ON_RESET != 0);

  // S1/S2 write pipeline plus the two read-side register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_req      <= '0;
      s1_addr     <= '0;
      s1_data     <= '0;
      s2_vld      <= '0;
      s2_addr     <= '0;
      s2_val      <= '0;
      wr_conflict <= '0;
      r1_vld      <= '0;
      r1_addr     <= '0;
      r2_vld      <= '0;
      r2_word     <= '0;
      rd_valid    <= '0;
      rd_data     <= '0;
    end else begin
      s1_req      <= wr_en & {WR_PORTS{ready}};
      s1_addr     <= wr_addr;
      s1_data     <= wr_data;
      s2_vld      <= s1_win;
      s2_addr     <= s1_addr;
      s2_val      <= s1_part;
      wr_conflict <= s1_req & ~s1_win;
      r1_vld      <= rd_en & {RD_PORTS{ready}};
      r1_addr     <= rd_addr;
      r2_vld      <= r1_vld;
      r2_word     <= r1_word;
      rd_valid    <= r2_vld;
      for (int r = 0; r < RD_PORTS; r++) begin
        if (r2_vld[r]) rd_data[r] <= r2_word[r];
      end
    end
  end

  // Collision resolution and partial XOR. A bank value sitting in S2 has not
  // committed yet, so it is forwarded in place of the stale array contents.
  always_comb begin
    s1_win  = '0;
    s1_part = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      s1_win[w]  = s1_req[w];
      for (int v = 0; v < w; v++) begin
        if (s1_req[v] && (s1_addr[v] == s1_addr[w])) s1_win[w] = 1'b0;
      end
      s1_part[w] = s1_data[w];
      for (int b = 0; b < WR_PORTS; b++) begin
        if (b != w) begin
          s1_part[w] = s1_part[w] ^
            ((s2_vld[b] && (s2_addr[b] == s1_addr[w])) ? s2_val[b]
                                                       : mem[b][(w < b) ? w : w - 1][s1_addr[w]]);
        end
      end
    end
  end

  // Read in the cycle after sampling: writes from two or more cycles earlier
  // are in the array, the one from the previous cycle is bypassed from S2, and
  // a same-cycle write is still in S1 and therefore invisible (read-old).
  always_comb begin
    r1_word = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      for (int b = 0; b < WR_PORTS; b++) begin
        r1_word[r] = r1_word[r] ^
          ((s2_vld[b] && (s2_addr[b] == r1_addr[r])) ? s2_val[b]
                                                     : mem[b][WR_PORTS - 1 + r][r1_addr[r]]);
      end
    end
  end

  // Bank storage: every copy of a bank receives the same write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WR_PORTS; b++) begin
      for (int c = 0; c < NCOPY; c++) begin
        if (init_we) begin
          mem[b][c][init_cnt] <= '0;
        end else if (s2_vld[b]) begin
          mem[b][c][s2_addr[b]] <= s2_val[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_multiport_ram_rw.sv
// tb_xor_multiport_ram_rw: directed self-checking bench for xor_multiport_ram_rw (default parameters).
// Latency: checks rd_valid/rd_data two edges after a read is sampled, wr_conflict one edge after a write.
// Backpressure: exercises requests during init, which must be ignored.
module tb_xor_multiport_ram_rw;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ready;
  logic [3:0]           wr_en;
  logic [3:0][8:0]      wr_addr;
  logic [3:0][31:0]     wr_data;
  logic [3:0]           wr_conflict;
  logic [3:0]           rd_en;
  logic [3:0][8:0]      rd_addr;
  logic [3:0]           rd_valid;
  logic [3:0][31:0]     rd_data;

  int total = 0;
  int bad   = 0;
  int cyc;

  xor_multiport_ram_rw dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_conflict (wr_conflict),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    rd_en = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 4'hF;
    rd_en   = 4'hF;
    wr_addr = '0;
    wr_data = '1;
    rd_addr = '0;
    step(); step(); step();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd_valid", {28'd0, rd_valid}, 32'd0);
    chk("rst_rd_data0", rd_data[0], 32'd0);
    chk("rst_conflict", {28'd0, wr_conflict}, 32'd0);
    idle();

    // First init, aborted at count 100.
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("init1_ready_at_100", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    step();
    chk("abort_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;

    // Second init: requests issued mid-init must have no effect.
    cyc = 0;
    while (!ready && cyc < 600) begin
      if (cyc == 50) begin
        wr_en      = 4'b0111;
        wr_addr[0] = 9'd20;  wr_data[0] = 32'h0000_0BAD;
        wr_addr[1] = 9'd21;  wr_data[1] = 32'h1234_5678;
        wr_addr[2] = 9'd21;  wr_data[2] = 32'h8765_4321;
        rd_en      = 4'b0001;
        rd_addr[0] = 9'd20;
      end else begin
        idle();
      end
      step();
      cyc++;
      chk("init_rd_valid", {28'd0, rd_valid}, 32'd0);
      chk("init_conflict", {28'd0, wr_conflict}, 32'd0);
    end
    idle();
    chk("ready_latency", cyc, 32'd512);

    // Zero sweep: every address reads 0.
    for (int i = 0; i < 130; i++) begin
      rd_en = (i < 128) ? 4'hF : 4'h0;
      for (int p = 0; p < 4; p++) rd_addr[p] = 9'(4 * i + p);
      step();
      if (i >= 2) begin
        chk("sweep_valid", {28'd0, rd_valid}, 32'hF);
        for (int p = 0; p < 4; p++) chk("sweep_data", rd_data[p], 32'd0);
      end
    end
    idle();

    // Read-old vs. read-after-write on A=5.
    wr_en = 4'b0001; wr_addr[0] = 9'd5; wr_data[0] = 32'hDEAD_BEEF;
    rd_en = 4'b0010; rd_addr[1] = 9'd5;
    step();
    wr_en = '0;
    step();
    rd_en = '0;
    step();
    chk("raw_same_cycle_valid", {28'd0, rd_valid}, 32'h2);
    chk("raw_same_cycle_data", rd_data[1], 32'd0);
    step();
    chk("raw_next_cycle_valid", {28'd0, rd_valid}, 32'h2);
    chk("raw_next_cycle_data", rd_data[1], 32'hDEAD_BEEF);
    step();
    chk("hold_valid", {28'd0, rd_valid}, 32'd0);
    chk("hold_data", rd_data[1], 32'hDEAD_BEEF);

    // Four distinct addresses in one cycle.
    wr_en = 4'hF;
    for (int p = 0; p < 4; p++) begin
      wr_addr[p] = 9'(p + 1);
      wr_data[p] = 32'(8'h11 * (p + 1));
    end
    step();
    idle();
    step();
    chk("distinct_conflict", {28'd0, wr_conflict}, 32'd0);
    step();
    rd_en = 4'hF;
    for (int p = 0; p < 4; p++) rd_addr[p] = 9'(p + 1);
    step();
    idle();
    step(); step();
    chk("distinct_rd0", rd_data[0], 32'h11);
    chk("distinct_rd1", rd_data[1], 32'h22);
    chk("distinct_rd2", rd_data[2], 32'h33);
    chk("distinct_rd3", rd_data[3], 32'h44);

    // Collision on A=9: port1 beats port2.
    wr_en = 4'b0110;
    wr_addr[1] = 9'd9; wr_data[1] = 32'h5555;
    wr_addr[2] = 9'd9; wr_data[2] = 32'hAAAA;
    step();
    idle();
    step();
    chk("collide_conflict_e1", {28'd0, wr_conflict}, 32'h4);
    step();
    chk("collide_conflict_after", {28'd0, wr_conflict}, 32'd0);
    rd_en = 4'b1000; rd_addr[3] = 9'd9;
    step();
    idle();
    step(); step();
    chk("collide_readback", rd_data[3], 32'h5555);

    // Back-to-back writes to A=7 from ports 0, 3, 1 with overlapping reads.
    wr_en = 4'b0001; wr_addr[0] = 9'd7; wr_data[0] = 32'h1;
    step();
    wr_en = 4'b1000; wr_addr[3] = 9'd7; wr_data[3] = 32'h2;
    rd_en = 4'b0001; rd_addr[0] = 9'd7;
    step();
    wr_en = 4'b0010; wr_addr[1] = 9'd7; wr_data[1] = 32'h3;
    step();
    wr_en = '0;
    rd_en = 4'hF;
    for (int p = 0; p < 4; p++) rd_addr[p] = 9'd7;
    step();
    idle();
    chk("b2b_read_t1", rd_data[0], 32'h1);
    step();
    chk("b2b_read_t2", rd_data[0], 32'h2);
    step();
    chk("b2b_valid_t3", {28'd0, rd_valid}, 32'hF);
    for (int p = 0; p < 4; p++) chk("b2b_read_t3", rd_data[p], 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
